// File: rtl/ddr_out_serializer_if.sv
// Handshake and ODDR-side bus of ddr_out_serializer: parallel words in, per-lane D1/D2 bit pairs out.
interface ddr_out_serializer_if #(
    parameter int CHANNELS = 2,
    parameter int WORD_W   = 8
);
    logic [CHANNELS*WORD_W-1:0] s_data;
    logic                       s_last;
    logic                       s_valid;
    logic                       s_ready;
    logic [CHANNELS-1:0]        q_d1;
    logic [CHANNELS-1:0]        q_d2;
    logic                       q_valid;
    logic                       q_last;

    modport master (
        output s_data, s_last, s_valid,
        input  s_ready, q_d1, q_d2, q_valid, q_last
    );

    modport slave (
        input  s_data, s_last, s_valid,
        output s_ready, q_d1, q_d2, q_valid, q_last
    );
endinterface

// File: rtl/ddr_out_serializer.sv
// Multi-lane word-to-ODDR serializer with one-word skid buffer, clock-enable pause,
// frame-end marking, idle insertion and sticky underrun detection.
module ddr_out_serializer #(
    parameter int   CHANNELS  = 2,
    parameter int   WORD_W    = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_VAL  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr_underrun,
    output logic                 underrun,
    ddr_out_serializer_if.slave  bus
);
    localparam int BEATS = WORD_W / 2;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    logic [CHANNELS*WORD_W-1:0]       hold_data;
    logic                             hold_last;
    logic                             hold_valid;
    logic [CHANNELS-1:0][WORD_W-1:0]  sh;
    logic [CW-1:0]                    cnt;
    logic                             last_flag;
    logic                             active;
    logic [CHANNELS-1:0]              d1_r;
    logic [CHANNELS-1:0]              d2_r;
    logic                             last_r;

    logic                             transfer;
    logic                             shift_free;
    logic                             load_hold;
    logic                             load_in;
    logic                             starve;
    logic [CHANNELS*WORD_W-1:0]       load_data;
    logic                             load_last;
    logic [CHANNELS-1:0][WORD_W-1:0]  norm;

    assign bus.s_ready = !hold_valid && !rst;
    assign transfer    = bus.s_valid && bus.s_ready;
    assign shift_free  = !active || (cnt == LAST_BEAT);
    assign load_hold   = en && shift_free && hold_valid;
    assign load_in     = en && shift_free && !hold_valid && transfer;
    assign starve      = en && active && (cnt == LAST_BEAT) && !last_flag
                         && !hold_valid && !transfer;
    assign load_data   = hold_valid ? hold_data : bus.s_data;
    assign load_last   = hold_valid ? hold_last : bus.s_last;

    // LSB-first words are bit-reversed on load so the shifter always emits from the top.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            for (int b = 0; b < WORD_W; b++) begin
                norm[c][b] = MSB_FIRST ? load_data[c*WORD_W + b]
                                       : load_data[c*WORD_W + WORD_W - 1 - b];
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_last  <= 1'b0;
            hold_data  <= '0;
        end else if (transfer && !load_in) begin
            hold_data  <= bus.s_data;
            hold_last  <= bus.s_last;
            hold_valid <= 1'b1;
        end else if (load_hold) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active    <= 1'b0;
            cnt       <= '0;
            last_flag <= 1'b0;
            sh        <= '0;
            d1_r      <= {CHANNELS{IDLE_VAL}};
            d2_r      <= {CHANNELS{IDLE_VAL}};
            last_r    <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            // Set is written after clear so a coincident starvation wins.
            if (clr_underrun) underrun <= 1'b0;
            if (starve)       underrun <= 1'b1;

            if (en) begin
                if (load_hold || load_in) begin
                    active    <= 1'b1;
                    cnt       <= '0;
                    last_flag <= load_last;
                    last_r    <= load_last && (BEATS == 1);
                    for (int c = 0; c < CHANNELS; c++) begin
                        sh[c]   <= norm[c] << 2;
                        d1_r[c] <= norm[c][WORD_W-1];
                        d2_r[c] <= norm[c][WORD_W-2];
                    end
                end else if (shift_free) begin
                    active <= 1'b0;
                    cnt    <= '0;
                    last_r <= 1'b0;
                    d1_r   <= {CHANNELS{IDLE_VAL}};
                    d2_r   <= {CHANNELS{IDLE_VAL}};
                end else begin
                    cnt    <= cnt + CW'(1);
                    last_r <= last_flag && ((cnt + CW'(1)) == LAST_BEAT);
                    for (int c = 0; c < CHANNELS; c++) begin
                        sh[c]   <= sh[c] << 2;
                        d1_r[c] <= sh[c][WORD_W-1];
                        d2_r[c] <= sh[c][WORD_W-2];
                    end
                end
            end
        end
    end

    assign bus.q_d1    = d1_r;
    assign bus.q_d2    = d2_r;
    assign bus.q_valid = active;
    assign bus.q_last  = last_r;
endmodule

// File: tb/tb_ddr_out_serializer.sv
// Randomised and directed bench for ddr_out_serializer, run on an MSB-first and an LSB-first
// instance in lockstep against a word-queue reference model.
module tb_ddr_out_serializer;
    localparam int CH = 2;
    localparam int W  = 8;
    localparam int B  = W / 2;

    typedef struct {
        logic [CH*W-1:0] data;
        bit              last;
    } word_t;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic clr;
    logic und_m, und_l;
    logic [CH*W-1:0] s_data;
    logic s_last, s_valid;

    always #5 clk = ~clk;

    ddr_out_serializer_if #(.CHANNELS(CH), .WORD_W(W)) bus_m ();
    ddr_out_serializer_if #(.CHANNELS(CH), .WORD_W(W)) bus_l ();

    assign bus_m.s_data  = s_data;
    assign bus_m.s_last  = s_last;
    assign bus_m.s_valid = s_valid;
    assign bus_l.s_data  = s_data;
    assign bus_l.s_last  = s_last;
    assign bus_l.s_valid = s_valid;

    ddr_out_serializer #(.CHANNELS(CH), .WORD_W(W), .MSB_FIRST(1'b1), .IDLE_VAL(1'b0)) dut (
        .clk(clk), .rst(rst), .en(en), .clr_underrun(clr), .underrun(und_m), .bus(bus_m.slave)
    );

    ddr_out_serializer #(.CHANNELS(CH), .WORD_W(W), .MSB_FIRST(1'b0), .IDLE_VAL(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .en(en), .clr_underrun(clr), .underrun(und_l), .bus(bus_l.slave)
    );

    // Reference model: pending words (skid buffer) plus the word currently on the wire.
    word_t pend[$];
    word_t cur;
    bit    m_active;
    int    m_pos;
    bit    m_under;
    bit    last_xfer;

    int n_tests = 0;
    int n_fail  = 0;
    int st_valid, st_last, st_rise, st_busy, st_p01;
    bit prev_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] beat_of(input logic [W-1:0] w, input int i, input bit msb);
        if (msb) return {w[W-1-2*i], w[W-2-2*i]};
        return {w[2*i], w[2*i+1]};
    endfunction

    function automatic logic [CH-1:0] exp_lane(input bit second, input bit msb);
        logic [CH-1:0] v;
        logic [1:0]    b;
        v = '0;
        for (int c = 0; c < CH; c++) begin
            if (m_active) begin
                b    = beat_of(cur.data[c*W +: W], m_pos, msb);
                v[c] = second ? b[0] : b[1];
            end
        end
        return v;
    endfunction

    task automatic model_reset();
        pend.delete();
        m_active = 1'b0;
        m_pos    = 0;
        m_under  = 1'b0;
    endtask

    task automatic check_outputs();
        bit exp_last;
        exp_last = m_active && cur.last && (m_pos == B - 1);
        check("q_valid",     bus_m.q_valid, m_active);
        check("q_valid_lsb", bus_l.q_valid, m_active);
        check("q_last",      bus_m.q_last,  exp_last);
        check("q_last_lsb",  bus_l.q_last,  exp_last);
        check("q_d1",        bus_m.q_d1,    exp_lane(1'b0, 1'b1));
        check("q_d2",        bus_m.q_d2,    exp_lane(1'b1, 1'b1));
        check("q_d1_lsb",    bus_l.q_d1,    exp_lane(1'b0, 1'b0));
        check("q_d2_lsb",    bus_l.q_d2,    exp_lane(1'b1, 1'b0));
        check("underrun",    und_m,         m_under);
        check("underrun_lsb", und_l,        m_under);
    endtask

    // One clock: check ready before the edge, advance the model at the edge, check outputs after.
    task automatic cycle();
        bit ready, xfer;
        ready = !rst && (pend.size() == 0);
        check("s_ready",     bus_m.s_ready, ready);
        check("s_ready_lsb", bus_l.s_ready, ready);
        if (!ready) st_busy++;
        xfer      = s_valid && ready;
        last_xfer = xfer;
        @(posedge clk);
        if (clr) m_under = 1'b0;
        if (en) begin
            if (m_active && m_pos < B - 1) begin
                m_pos++;
            end else if (pend.size() > 0) begin
                cur      = pend.pop_front();
                m_pos    = 0;
                m_active = 1'b1;
            end else if (xfer) begin
                cur      = '{data: s_data, last: s_last};
                xfer     = 1'b0;
                m_pos    = 0;
                m_active = 1'b1;
            end else begin
                if (m_active && !cur.last) m_under = 1'b1;
                m_active = 1'b0;
            end
        end
        if (xfer) pend.push_back('{data: s_data, last: s_last});
        #1;
        check_outputs();
        if (bus_m.q_valid === 1'b1) begin
            st_valid++;
            if (!prev_valid) st_rise++;
            if (bus_m.q_last === 1'b1) st_last++;
            if (bus_m.q_d1[0] === 1'b0 && bus_m.q_d2[0] === 1'b1) st_p01++;
        end
        prev_valid = (bus_m.q_valid === 1'b1);
    endtask

    task automatic clear_stats();
        st_valid = 0; st_last = 0; st_rise = 0; st_busy = 0; st_p01 = 0;
    endtask

    task automatic drain(input int n);
        s_valid = 1'b0; en = 1'b1; clr = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send(input logic [CH*W-1:0] d, input bit l);
        bit ok;
        s_data = d; s_last = l; s_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            cycle();
            ok = last_xfer;
        end
        check("accept_in_time", ok, 1'b1);
        s_valid = 1'b0;
    endtask

    logic [7:0] obs0, obs1, obs0_l;
    logic [CH*W-1:0] rw;

    initial begin
        rst = 1'b1; en = 1'b1; clr = 1'b0;
        s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        prev_valid = 1'b0;
        model_reset();
        clear_stats();

        // Reset state
        #12;
        check("rst_q_valid", bus_m.q_valid, 1'b0);
        check("rst_q_d1",    bus_m.q_d1,    2'b00);
        check("rst_q_d2",    bus_m.q_d2,    2'b00);
        check("rst_s_ready", bus_m.s_ready, 1'b0);
        check("rst_underrun", und_m,        1'b0);
        @(posedge clk); #1 rst = 1'b0;
        #1 check("rel_s_ready", bus_m.s_ready, 1'b1);
        drain(2);

        // Single word 0x0F/0xA5 with last
        clear_stats();
        obs0 = '0; obs1 = '0; obs0_l = '0;
        send({8'h0F, 8'hA5}, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (bus_m.q_valid === 1'b1) begin
                obs0   = {obs0[5:0],   bus_m.q_d1[0], bus_m.q_d2[0]};
                obs1   = {obs1[5:0],   bus_m.q_d1[1], bus_m.q_d2[1]};
                obs0_l = {obs0_l[5:0], bus_l.q_d1[0], bus_l.q_d2[0]};
            end
            if (i < 5) cycle();
        end
        check("single_lane0_beats", obs0,   8'hA5);
        check("single_lane1_beats", obs1,   8'h0F);
        check("lsb_lane0_beats",    obs0_l, 8'hA5);
        check("single_valid_cycles", st_valid, 4);
        check("single_last_cycles",  st_last,  1);
        check("single_no_underrun",  und_m,    1'b0);
        drain(2);

        // Back-to-back stream of three words
        clear_stats();
        send(16'h1234, 1'b0);
        send(16'hBEEF, 1'b0);
        send(16'h5A3C, 1'b1);
        drain(14);
        check("b2b_valid_cycles", st_valid, 12);
        check("b2b_single_burst", st_rise,  1);
        check("b2b_ready_dropped", st_busy > 0, 1'b1);
        check("b2b_last_cycles",  st_last,  1);
        check("b2b_no_underrun",  und_m,    1'b0);

        // Underrun: unterminated word with no follow-up
        send(16'hC3C3, 1'b0);
        for (int i = 0; i < 4; i++) cycle();
        check("under_set",       und_m,         1'b1);
        check("under_idle",      bus_m.q_valid, 1'b0);
        check("under_idle_d1",   bus_m.q_d1,    2'b00);
        drain(3);
        check("under_sticky",    und_m,         1'b1);
        clr = 1'b1; cycle(); clr = 1'b0;
        check("under_cleared",   und_m,         1'b0);
        drain(2);

        // Pause for three cycles on beat 2
        clear_stats();
        send({8'h3C, 8'hA5}, 1'b1);
        cycle();
        cycle();
        en = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        en = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        check("pause_valid_cycles", st_valid, 7);
        check("pause_01_cycles",    st_p01,   5);
        check("pause_last_cycles",  st_last,  1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            en  = ($urandom_range(9) != 0);
            clr = ($urandom_range(19) == 0);
            if (!(s_valid && !last_xfer)) begin
                s_valid = ($urandom_range(9) < 7);
                rw      = CH*W'($urandom);
                s_data  = rw;
                s_last  = ($urandom_range(2) == 0);
            end
            cycle();
        end
        drain(10);
        clr = 1'b1; cycle(); clr = 1'b0;

        // Async reset mid-word with a word waiting in hold
        send(16'h9966, 1'b0);
        s_data = 16'h7777; s_last = 1'b1; s_valid = 1'b1;
        cycle();
        s_valid = 1'b0;
        check("pre_rst_hold_full", bus_m.s_ready, 1'b0);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check("arst_q_valid", bus_m.q_valid, 1'b0);
        check("arst_q_d1",    bus_m.q_d1,    2'b00);
        check("arst_q_d2",    bus_m.q_d2,    2'b00);
        check("arst_s_ready", bus_m.s_ready, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        #1 check("arst_rel_ready", bus_m.s_ready, 1'b1);
        clear_stats();
        drain(6);
        check("arst_hold_discarded", st_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
